dm_store_buffer: RTL and testbench

- Sits between the MEM-stage load/store decode and the word-wide data memory (one address port, combinational read, posedge write, write-enable).
- Converts sb/sh/sw into lane-aligned masked entries and queues them in a small in-order FIFO.
- Drains entries into the data memory with a same-cycle read-modify-write; serves lb/lbu/lh/lhu/lw with lane select and extension.
- Stalls the pipeline on buffer-full or on a load hitting a pending store.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/dm_store_buffer_if.sv | 11 +
 rtl/dm_load_ext.sv | 35 +++
 rtl/dm_store_buffer.sv | 147 ++++++++++++++
 tb/tb_dm_store_buffer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: access sizes, the store-buffer entry layout
// and lane/byte mask helpers used by the store buffer and its load extender.
package mem_pkg;

    localparam int DM_AW = 10;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef struct packed {
        logic [DM_AW-1:0] waddr;
        logic [3:0]       mask;
        logic [31:0]      data;
    } sb_entry_t;

    function automatic logic [31:0] mask_to_bytemask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Reserved size counts as misaligned so the whole request is dropped.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (size_e'(sz))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// Word-wide data-memory port: one address, combinational read, posedge write.
interface dm_store_buffer_if;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    // Buffer side drives address/write; the memory returns read data in the same cycle.
    modport master (output dm_we, output dm_addr, output dm_wd, input dm_rd);
    modport slave  (input dm_we, input dm_addr, input dm_wd, output dm_rd);
endinterface

// File: rtl/dm_load_ext.sv
// Load lane select: picks the byte/half/word addressed by byte_off out of the
// memory word and sign- or zero-extends it to 32 bits.
module dm_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'h00;
        lane_h = 16'h0000;
        data   = 32'h0000_0000;
        case (byte_off)
            2'b00:   lane_b = rd[7:0];
            2'b01:   lane_b = rd[15:8];
            2'b10:   lane_b = rd[23:16];
            default: lane_b = rd[31:24];
        endcase
        lane_h = byte_off[1] ? rd[31:16] : rd[15:0];
        case (size_e'(size))
            SZ_BYTE: data = {{24{lane_b[7] & ~ld_unsigned}}, lane_b};
            SZ_HALF: data = {{16{lane_h[15] & ~ld_unsigned}}, lane_h};
            SZ_WORD: data = rd;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store buffer in front of a word-wide data memory: queues masked
// stores, drains them with read-modify-write, and serves loads with extension.
module dm_store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DM_AW   // must match DM_AW, the entry waddr width
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_req,
    input  logic        st_req,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        misalign_exc,
    output logic        empty,
    dm_store_buffer_if.master dm
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW:0]      count_q, count_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    sb_entry_t        entry_q [DEPTH];
    sb_entry_t        entry_d [DEPTH];

    logic        ld_act, st_act, mis, ld_v, st_v;
    logic        hit, full, stall_int, drain, push;
    sb_entry_t   new_e, head_e;
    logic [31:0] head_bm;
    logic [31:0] ext_data;

    dm_load_ext u_load_ext (
        .rd          (dm.dm_rd),
        .byte_off    (addr[1:0]),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .data        (ext_data)
    );

    // A simultaneous load and store is treated as a load alone.
    always_comb begin
        ld_act = ld_req;
        st_act = st_req && !ld_req;
        mis    = (ld_act || st_act) && is_misaligned(size, addr[1:0]);
        ld_v   = ld_act && !mis;
        st_v   = st_act && !mis;

        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i].waddr == addr[AW+1:2])) begin
                hit = 1'b1;
            end
        end
        hit = hit && ld_v;

        full      = (count_q == FULL_CNT);
        stall_int = (st_v && full) || (ld_v && hit);
        drain     = (count_q != '0) && (stall_int || (!ld_req && !st_req));
        push      = st_v && !stall_int;
    end

    always_comb begin
        new_e       = '0;
        new_e.waddr = addr[AW+1:2];
        case (size_e'(size))
            SZ_BYTE: begin
                new_e.mask = 4'b0001 << addr[1:0];
                new_e.data = {24'h000000, st_data[7:0]} << {addr[1:0], 3'b000};
            end
            SZ_HALF: begin
                new_e.mask = addr[1] ? 4'b1100 : 4'b0011;
                new_e.data = addr[1] ? {st_data[15:0], 16'h0000} : {16'h0000, st_data[15:0]};
            end
            default: begin
                new_e.mask = 4'b1111;
                new_e.data = st_data;
            end
        endcase
    end

    always_comb begin
        head_e  = entry_q[head_q];
        head_bm = mask_to_bytemask(head_e.mask);

        dm.dm_we   = drain && !reset;
        dm.dm_addr = drain ? {{(30-AW){1'b0}}, head_e.waddr, 2'b00} : {addr[31:2], 2'b00};
        dm.dm_wd   = drain ? ((dm.dm_rd & ~head_bm) | (head_e.data & head_bm)) : 32'h0000_0000;

        stall        = stall_int && !reset;
        misalign_exc = mis && !reset;
        ld_data      = (ld_v && !stall_int && !reset) ? ext_data : 32'h0000_0000;
        empty        = (count_q == '0) || reset;
    end

    // Push and drain never coincide (a push needs st_req, a drain then needs a stall),
    // but both are handled independently so the pointer logic stays uniform.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        entry_d = entry_q;
        if (push) begin
            entry_d[tail_q] = new_e;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: a byte-addressed architectural memory model is
// compared against loads and against the data memory once the buffer drains.
module tb_dm_store_buffer;
    import mem_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req, st_req, ld_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, st_data;
    logic        stall, misalign_exc, empty;
    logic [31:0] ld_data;

    dm_store_buffer_if dmif ();

    logic [31:0] mem [0:1023];
    logic        bk_we;
    logic [9:0]  bk_idx;
    logic [31:0] bk_data;

    logic [7:0]  ref_mem [0:4095];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign dmif.dm_rd = mem[dmif.dm_addr[11:2]];

    always @(posedge clk) begin
        if (bk_we) mem[bk_idx] <= bk_data;
        else if (dmif.dm_we) mem[dmif.dm_addr[11:2]] <= dmif.dm_wd;
    end

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_req       (ld_req),
        .st_req       (st_req),
        .size         (size),
        .ld_unsigned  (ld_unsigned),
        .addr         (addr),
        .st_data      (st_data),
        .stall        (stall),
        .ld_data      (ld_data),
        .misalign_exc (misalign_exc),
        .empty        (empty),
        .dm           (dmif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural value a load must return, from little-endian bytes.
    function automatic logic [31:0] ld_ref(input int a, input logic [1:0] sz, input bit uns);
        int unsigned v;
        case (sz)
            2'd0: begin
                v = 32'(ref_mem[a]);
                if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                v = 32'(ref_mem[a]) + 256 * 32'(ref_mem[a+1]);
                if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = 32'(ref_mem[a]) + 256 * 32'(ref_mem[a+1])
                       + 65536 * 32'(ref_mem[a+2]) + 16777216 * 32'(ref_mem[a+3]);
        endcase
        return v;
    endfunction

    task automatic st_ref(input int a, input logic [1:0] sz, input logic [31:0] d);
        int nb = 1 << sz;
        for (int k = 0; k < nb; k++) ref_mem[a+k] = 8'(d >> (8*k));
    endtask

    task automatic go_idle(input int n);
        ld_req = 1'b0;
        st_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_store(input int a, input logic [1:0] sz, input logic [31:0] d);
        int n = 0;
        ld_req = 1'b0; st_req = 1'b1; ld_unsigned = 1'b0;
        addr = 32'(a); size = sz; st_data = d;
        #1;
        while (stall && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk($sformatf("st_accept@%0h", a), 32'(stall), 32'd0);
        st_ref(a, sz, d);
        @(negedge clk);
    endtask

    task automatic do_load(input int a, input logic [1:0] sz, input bit uns, output logic [31:0] got);
        int n = 0;
        ld_req = 1'b1; st_req = 1'b0; ld_unsigned = uns;
        addr = 32'(a); size = sz;
        #1;
        while (stall && n < 20) begin
            @(negedge clk); #1; n++;
        end
        got = ld_data;
        exp_q.push_back(ld_ref(a, sz, uns));
        chk($sformatf("ld_stall_end@%0h", a), 32'(stall), 32'd0);
        chk($sformatf("ld_sz%0d_u%0d@%0h", sz, uns, a), got, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic wait_empty();
        int n = 0;
        ld_req = 1'b0; st_req = 1'b0;
        #1;
        while (!empty && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("drain_to_empty", 32'(empty), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, got;
        logic [7:0]  snap [12];
        logic [1:0]  sz;
        int          w, a, op;

        reset = 1'b1; ld_req = 1'b0; st_req = 1'b0; ld_unsigned = 1'b0;
        size = 2'b10; addr = '0; st_data = '0;
        bk_we = 1'b0; bk_idx = '0; bk_data = '0;

        // clock/reset: preload memory through the backdoor while reset is held
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            r = $urandom;
            bk_we = 1'b1; bk_idx = 10'(i); bk_data = r;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = r[8*k +: 8];
            @(negedge clk);
        end
        bk_we = 1'b0;

        ld_req = 1'b1; size = 2'b01; addr = 32'h1;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dm_we", 32'(dmif.dm_we), 32'd0);
        chk("rst_misalign", 32'(misalign_exc), 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        ld_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // load hit on a just-accepted store
        st_req = 1'b1; size = 2'b10; addr = 32'h10; st_data = 32'h1234_5678;
        #1;
        chk("hit_st_stall", 32'(stall), 32'd0);
        st_ref(32'h10, 2'b10, 32'h1234_5678);
        @(negedge clk);
        st_req = 1'b0; ld_req = 1'b1; ld_unsigned = 1'b0;
        #1;
        chk("hit_stall", 32'(stall), 32'd1);
        chk("hit_dm_we", 32'(dmif.dm_we), 32'd1);
        chk("hit_dm_addr", dmif.dm_addr, 32'h10);
        chk("hit_dm_wd", dmif.dm_wd, 32'h1234_5678);
        @(negedge clk);
        #1;
        chk("hit_stall_after", 32'(stall), 32'd0);
        chk("hit_ld_data", ld_data, 32'h1234_5678);
        @(negedge clk);
        go_idle(1);

        // partial store merge and load extension
        do_store(32'h10, 2'b10, 32'h1122_3344);
        wait_empty();
        do_store(32'h13, 2'b00, 32'hCDEF_01AB);
        wait_empty();
        chk("part_word", mem[4], 32'hAB22_3344);
        do_load(32'h13, 2'b00, 1'b0, got); chk("part_lb", got, 32'hFFFF_FFAB);
        do_load(32'h13, 2'b00, 1'b1, got); chk("part_lbu", got, 32'h0000_00AB);
        do_load(32'h12, 2'b01, 1'b0, got); chk("part_lh", got, 32'hFFFF_AB22);
        do_load(32'h10, 2'b01, 1'b1, got); chk("part_lhu", got, 32'h0000_3344);

        // full buffer: fifth store waits one cycle while the oldest entry drains
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            ld_req = 1'b0; st_req = 1'b1; size = 2'b10; addr = 32'(4*i); st_data = r;
            #1;
            chk($sformatf("full_nostall%0d", i), 32'(stall), 32'd0);
            st_ref(4*i, 2'b10, r);
            @(negedge clk);
        end
        r = $urandom;
        addr = 32'h10; st_data = r;
        #1;
        chk("full_stall", 32'(stall), 32'd1);
        chk("full_drain_we", 32'(dmif.dm_we), 32'd1);
        chk("full_drain_addr", dmif.dm_addr, 32'h0);
        @(negedge clk);
        #1;
        chk("full_accept", 32'(stall), 32'd0);
        st_ref(32'h10, 2'b10, r);
        @(negedge clk);
        ld_req = 1'b0; st_req = 1'b0;
        #1;
        chk("full_not_empty", 32'(empty), 32'd0);
        @(negedge clk);
        go_idle(4);
        #1;
        chk("full_empty_after5", 32'(empty), 32'd1);
        @(negedge clk);

        // ordering: younger byte store lands over an older half store
        do_store(32'h20, 2'b10, 32'h0);
        do_store(32'h22, 2'b01, 32'h5555_BEEF);
        do_store(32'h20, 2'b00, 32'h7777_7701);
        wait_empty();
        chk("order_word", mem[8], 32'hBEEF_0001);

        // misaligned and reserved-size requests are dropped without stalling
        do_store(32'h40, 2'b10, $urandom);
        ld_req = 1'b1; st_req = 1'b0; size = 2'b01; addr = 32'h21;
        #1;
        chk("mis_lh_exc", 32'(misalign_exc), 32'd1);
        chk("mis_lh_stall", 32'(stall), 32'd0);
        chk("mis_lh_data", ld_data, 32'd0);
        chk("mis_lh_no_drain", 32'(dmif.dm_we), 32'd0);
        @(negedge clk);
        ld_req = 1'b0; st_req = 1'b1; size = 2'b10; addr = 32'h22; st_data = 32'hDEAD_BEEF;
        #1;
        chk("mis_sw_exc", 32'(misalign_exc), 32'd1);
        chk("mis_sw_stall", 32'(stall), 32'd0);
        chk("mis_sw_count", 32'(empty), 32'd0);
        @(negedge clk);
        size = 2'b11; addr = 32'h24;
        #1;
        chk("mis_rsvd_exc", 32'(misalign_exc), 32'd1);
        chk("mis_rsvd_stall", 32'(stall), 32'd0);
        @(negedge clk);
        wait_empty();
        chk("mis_word_kept", mem[8], 32'hBEEF_0001);

        // reset mid-drain discards pending stores
        for (int k = 0; k < 12; k++) snap[k] = ref_mem[32'h30 + k];
        do_store(32'h30, 2'b10, $urandom);
        do_store(32'h34, 2'b10, $urandom);
        do_store(32'h38, 2'b10, $urandom);
        ld_req = 1'b0; st_req = 1'b0;
        #1;
        chk("rst_mid_pending", 32'(empty), 32'd0);
        chk("rst_mid_draining", 32'(dmif.dm_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_empty", 32'(empty), 32'd1);
        chk("rst_mid_we", 32'(dmif.dm_we), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        for (int k = 0; k < 12; k++) ref_mem[32'h30 + k] = snap[k];
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) do_load(32'h30 + 4*i, 2'b10, 1'b0, got);

        // randomized traffic over a small window so hits are frequent
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            w  = $urandom_range(0, 15);
            sz = 2'($urandom_range(0, 2));
            a  = 32'h100 + 4*w;
            if (sz == 2'd0) a = a + $urandom_range(0, 3);
            else if (sz == 2'd1) a = a + 2*$urandom_range(0, 1);
            if (op <= 3) begin
                do_load(a, sz, 1'($urandom_range(0, 1)), got);
            end else if (op <= 6) begin
                do_store(a, sz, $urandom);
            end else if (op == 7) begin
                go_idle($urandom_range(1, 3));
            end else if (op == 8) begin
                ld_req = 1'($urandom_range(0, 1)); st_req = !ld_req;
                size = 2'($urandom_range(1, 3)); st_data = $urandom;
                addr = 32'(32'h100 + 4*w + ((size == 2'b01) ? 1 : 2));
                #1;
                chk("rnd_mis_exc", 32'(misalign_exc), 32'd1);
                chk("rnd_mis_stall", 32'(stall), 32'd0);
                chk("rnd_mis_data", ld_data, 32'd0);
                @(negedge clk);
            end else begin
                do_store(a, sz, $urandom);
                do_load(a & ~3, 2'b10, 1'b0, got);
            end
        end
        wait_empty();

        // final scoreboard: drained memory against the architectural model
        for (int i = 0; i < 16; i++) chk($sformatf("mem_lo%0d", i), mem[i], ld_ref(4*i, 2'b10, 1'b1));
        for (int i = 0; i < 16; i++) chk($sformatf("mem_rnd%0d", i), mem[64+i], ld_ref(32'h100 + 4*i, 2'b10, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
